// File: rtl/sd_card_pkg.sv
`default_nettype none
// ============================================================================
// sd_card_pkg : shared types and R1 field helpers for SD card state control
// Revision    : 1.0
// ============================================================================
package sd_card_pkg;

  typedef enum logic [3:0] {
    CS_IDLE  = 4'd0,
    CS_READY = 4'd1,
    CS_IDENT = 4'd2,
    CS_STBY  = 4'd3,
    CS_TRAN  = 4'd4,
    CS_DATA  = 4'd5,
    CS_RCV   = 4'd6,
    CS_PRG   = 4'd7,
    CS_DIS   = 4'd8
  } card_state_e;

  typedef enum logic [2:0] {
    FC_NONE          = 3'd0,
    FC_BUSY_TMO      = 3'd1,
    FC_ILLEGAL_STATE = 3'd2,
    FC_RETRIES       = 3'd3,
    FC_RESP_TMO      = 3'd4,
    FC_R1_ERROR      = 3'd5
  } fail_code_e;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_DELAY      = 4'd1,
    ST_BUSY_WAIT  = 4'd2,
    ST_SEND_CMD13 = 4'd3,
    ST_GET_CMD13  = 4'd4,
    ST_EVAL       = 4'd5,
    ST_SEND_CMD7  = 4'd6,
    ST_GET_CMD7   = 4'd7,
    ST_PASS       = 4'd8,
    ST_FAIL       = 4'd9
  } ctrl_state_e;

  localparam logic [5:0] CMD_SELECT      = 6'd7;
  localparam logic [5:0] CMD_SEND_STATUS = 6'd13;

  localparam int R1_STATE_HI = 20;
  localparam int R1_STATE_LO = 17;
  localparam int R1_ERR_HI   = 39;
  localparam int R1_ERR_LO   = 27;

  function automatic card_state_e r1_state(input logic [47:0] resp);
    return card_state_e'(resp[R1_STATE_HI:R1_STATE_LO]);
  endfunction

  function automatic logic r1_has_error(input logic [47:0] resp);
    return |resp[R1_ERR_HI:R1_ERR_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_timeout_counter.sv
`default_nettype none
// ============================================================================
// sd_timeout_counter : saturating cycle counter with two selectable limits
// Revision           : 1.0
// ============================================================================
module sd_timeout_counter #(
  parameter int WIDTH   = 16,
  parameter int LIMIT_A = 65535,
  parameter int LIMIT_B = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic use_b_i,
  output logic expired_o
);

  localparam logic [WIDTH-1:0] LAST_A = WIDTH'(LIMIT_A - 1);
  localparam logic [WIDTH-1:0] LAST_B = WIDTH'(LIMIT_B - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] last;

  assign last      = use_b_i ? LAST_B : LAST_A;
  assign expired_o = (count_q == last);

  // Holds at the limit so expired stays asserted until the owner clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_card_state_ctrl.sv
`default_nettype none
// ============================================================================
// sd_card_state_ctrl : drives an SD card into TRAN or STBY using CMD13 / CMD7
// Revision           : 1.0
// ============================================================================
module sd_card_state_ctrl
  import sd_card_pkg::*;
#(
  parameter int DELAY_CYCLES   = 31,
  parameter int RESP_TIMEOUT   = 256,
  parameter int BUSY_TIMEOUT   = 65535,
  parameter int MAX_RETRIES    = 3,
  parameter int CHECK_ERR_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_En,
  input  logic        Target_Sel,
  output logic        Done,
  output logic        Fail,
  output logic [2:0]  Fail_Code,
  output logic [3:0]  Card_State,
  input  logic        Busy_Bit,
  input  logic [15:0] RCA_Addr,
  input  logic [47:0] Responce_R1_R3,
  output logic [5:0]  CMD_ID,
  output logic [7:0]  Arg1,
  output logic [7:0]  Arg2,
  output logic [7:0]  Arg3,
  output logic [7:0]  Arg4,
  output logic        Send_CMD_En,
  output logic        Get_CMD_En,
  input  logic        Send_CMD_Complite,
  input  logic        Get_CMD_Complite
);

  localparam int TMO_MAX = (BUSY_TIMEOUT > RESP_TIMEOUT) ? BUSY_TIMEOUT : RESP_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);
  localparam int DLY_W   = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RTY_W   = $clog2(MAX_RETRIES + 2);

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  ctrl_state_e      state_q;
  logic             target_q;
  logic [RTY_W-1:0] retry_q;
  logic [DLY_W-1:0] dly_q;
  logic             done_q;
  logic             fail_q;
  fail_code_e       fail_code_q;
  card_state_e      card_state_q;
  logic [5:0]       cmd_id_q;
  logic [7:0]       arg1_q;
  logic [7:0]       arg2_q;
  logic [7:0]       arg3_q;
  logic [7:0]       arg4_q;
  logic             send_en_q;
  logic             get_en_q;

  logic        abort;
  logic        tmo_en;
  logic        tmo_expired;
  card_state_e tgt_state;
  logic        need_cmd7;
  logic        transient;
  logic        retry_ok;
  logic        resp_err;
  logic        unused_resp;

  assign abort     = !Req_En && !(state_q inside {ST_IDLE, ST_PASS, ST_FAIL});
  assign tmo_en    = state_q inside {ST_BUSY_WAIT, ST_GET_CMD13, ST_GET_CMD7};
  assign tgt_state = target_q ? CS_STBY : CS_TRAN;
  assign need_cmd7 = (!target_q && card_state_q == CS_STBY) ||
                     ( target_q && card_state_q == CS_TRAN);
  assign transient = card_state_q inside {CS_DATA, CS_RCV, CS_PRG};
  assign retry_ok  = (retry_q < RTY_MAX);
  assign resp_err  = (CHECK_ERR_BITS != 0) && r1_has_error(Responce_R1_R3);

  assign unused_resp = ^{Responce_R1_R3[47:40], Responce_R1_R3[26:21], Responce_R1_R3[16:0]};

  // Timed states are never adjacent, so clearing whenever idle gives a fresh count on entry.
  sd_timeout_counter #(
    .WIDTH   (TMO_W),
    .LIMIT_A (BUSY_TIMEOUT),
    .LIMIT_B (RESP_TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!tmo_en),
    .en_i      (tmo_en),
    .use_b_i   (state_q != ST_BUSY_WAIT),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      target_q     <= 1'b0;
      retry_q      <= '0;
      dly_q        <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FC_NONE;
      card_state_q <= CS_IDLE;
      cmd_id_q     <= '0;
      arg1_q       <= '0;
      arg2_q       <= '0;
      arg3_q       <= '0;
      arg4_q       <= '0;
      send_en_q    <= 1'b0;
      get_en_q     <= 1'b0;
    end else if (abort) begin
      send_en_q <= 1'b0;
      get_en_q  <= 1'b0;
      dly_q     <= '0;
      state_q   <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Req_En) begin
            target_q    <= Target_Sel;
            retry_q     <= '0;
            fail_code_q <= FC_NONE;
            dly_q       <= '0;
            state_q     <= ST_DELAY;
          end
        end

        ST_DELAY: begin
          if (dly_q == DLY_LAST) begin
            dly_q   <= '0;
            state_q <= ST_BUSY_WAIT;
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end

        ST_BUSY_WAIT: begin
          if (Busy_Bit) begin
            cmd_id_q           <= CMD_SEND_STATUS;
            {arg1_q, arg2_q}   <= RCA_Addr;
            arg3_q             <= '0;
            arg4_q             <= '0;
            send_en_q          <= 1'b1;
            state_q            <= ST_SEND_CMD13;
          end else if (tmo_expired) begin
            fail_code_q <= FC_BUSY_TMO;
            state_q     <= ST_FAIL;
          end
        end

        ST_SEND_CMD13: begin
          if (Send_CMD_Complite) begin
            send_en_q <= 1'b0;
            get_en_q  <= 1'b1;
            state_q   <= ST_GET_CMD13;
          end
        end

        ST_GET_CMD13: begin
          if (Get_CMD_Complite) begin
            get_en_q     <= 1'b0;
            card_state_q <= r1_state(Responce_R1_R3);
            state_q      <= ST_EVAL;
          end else if (tmo_expired) begin
            get_en_q    <= 1'b0;
            fail_code_q <= FC_RESP_TMO;
            state_q     <= ST_FAIL;
          end
        end

        ST_EVAL: begin
          if (resp_err) begin
            fail_code_q <= FC_R1_ERROR;
            state_q     <= ST_FAIL;
          end else if (card_state_q == tgt_state) begin
            state_q <= ST_PASS;
          end else if (need_cmd7 || transient) begin
            if (!retry_ok) begin
              fail_code_q <= FC_RETRIES;
              state_q     <= ST_FAIL;
            end else if (need_cmd7) begin
              // Deselect addresses RCA 0 so every card drops to STBY.
              cmd_id_q         <= CMD_SELECT;
              {arg1_q, arg2_q} <= target_q ? 16'h0000 : RCA_Addr;
              arg3_q           <= '0;
              arg4_q           <= '0;
              send_en_q        <= 1'b1;
              state_q          <= ST_SEND_CMD7;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= ST_DELAY;
            end
          end else begin
            fail_code_q <= FC_ILLEGAL_STATE;
            state_q     <= ST_FAIL;
          end
        end

        ST_SEND_CMD7: begin
          if (Send_CMD_Complite) begin
            send_en_q <= 1'b0;
            if (!target_q) begin
              get_en_q <= 1'b1;
              state_q  <= ST_GET_CMD7;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= ST_DELAY;
            end
          end
        end

        ST_GET_CMD7: begin
          if (Get_CMD_Complite) begin
            get_en_q <= 1'b0;
            retry_q  <= retry_q + 1'b1;
            state_q  <= ST_DELAY;
          end else if (tmo_expired) begin
            get_en_q    <= 1'b0;
            fail_code_q <= FC_RESP_TMO;
            state_q     <= ST_FAIL;
          end
        end

        ST_PASS: begin
          if (!Req_En) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        ST_FAIL: begin
          if (!Req_En) begin
            fail_q      <= 1'b0;
            fail_code_q <= FC_NONE;
            state_q     <= ST_IDLE;
          end else begin
            fail_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Done        = done_q;
  assign Fail        = fail_q;
  assign Fail_Code   = fail_code_q;
  assign Card_State  = card_state_q;
  assign CMD_ID      = cmd_id_q;
  assign Arg1        = arg1_q;
  assign Arg2        = arg2_q;
  assign Arg3        = arg3_q;
  assign Arg4        = arg4_q;
  assign Send_CMD_En = send_en_q;
  assign Get_CMD_En  = get_en_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_card_state_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sd_card_state_ctrl : directed bench with a behavioural CMD engine and card
// Revision              : 1.0
// ============================================================================
module tb_sd_card_state_ctrl;

  localparam int DLY = 4;
  localparam int RTO = 16;
  localparam int BTO = 20;
  localparam int MR  = 3;
  localparam logic [15:0] RCA = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Req_En = 1'b0;
  logic        Target_Sel = 1'b0;
  logic        Done;
  logic        Fail;
  logic [2:0]  Fail_Code;
  logic [3:0]  Card_State;
  logic        Busy_Bit = 1'b1;
  logic [15:0] RCA_Addr = RCA;
  logic [47:0] Responce_R1_R3;
  logic [5:0]  CMD_ID;
  logic [7:0]  Arg1, Arg2, Arg3, Arg4;
  logic        Send_CMD_En, Get_CMD_En;
  logic        Send_CMD_Complite, Get_CMD_Complite;

  always #5 clk = ~clk;

  sd_card_state_ctrl #(
    .DELAY_CYCLES   (DLY),
    .RESP_TIMEOUT   (RTO),
    .BUSY_TIMEOUT   (BTO),
    .MAX_RETRIES    (MR),
    .CHECK_ERR_BITS (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .Req_En            (Req_En),
    .Target_Sel        (Target_Sel),
    .Done              (Done),
    .Fail              (Fail),
    .Fail_Code         (Fail_Code),
    .Card_State        (Card_State),
    .Busy_Bit          (Busy_Bit),
    .RCA_Addr          (RCA_Addr),
    .Responce_R1_R3    (Responce_R1_R3),
    .CMD_ID            (CMD_ID),
    .Arg1              (Arg1),
    .Arg2              (Arg2),
    .Arg3              (Arg3),
    .Arg4              (Arg4),
    .Send_CMD_En       (Send_CMD_En),
    .Get_CMD_En        (Get_CMD_En),
    .Send_CMD_Complite (Send_CMD_Complite),
    .Get_CMD_Complite  (Get_CMD_Complite)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Engine/card model state (owned by the engine process)
  int          cnt13 = 0, cnt7 = 0, get7 = 0, getcyc = 0;
  int          scnt = 0, gcnt = 0;
  logic [31:0] arg7 = '0;
  logic [3:0]  card_now = 4'd0;
  logic [5:0]  last_cmd = '0;

  // Configuration (owned by the main process)
  logic [3:0]  card_cfg = 4'd4;
  logic [47:0] err_mask = '0;
  int          get_lat = 1;
  bit          get_never = 1'b0;
  bit          send_never = 1'b0;

  initial begin
    Send_CMD_Complite = 1'b0;
    Get_CMD_Complite  = 1'b0;
    Responce_R1_R3    = '0;
    forever begin
      @(negedge clk);
      if (!Req_En) card_now = card_cfg;
      if (Get_CMD_En) getcyc++;
      if (Send_CMD_Complite) begin
        Send_CMD_Complite = 1'b0;
      end else if (Send_CMD_En && !send_never) begin
        if (scnt == 1) begin
          Send_CMD_Complite = 1'b1;
          scnt = 0;
          last_cmd = CMD_ID;
          if (CMD_ID == 6'd13) begin
            cnt13++;
          end else if (CMD_ID == 6'd7) begin
            cnt7++;
            arg7 = {Arg1, Arg2, Arg3, Arg4};
            if (arg7[31:16] != 16'd0 && card_now == 4'd3) card_now = 4'd4;
            else if (arg7[31:16] == 16'd0 && card_now == 4'd4) card_now = 4'd3;
          end
        end else begin
          scnt++;
        end
      end else begin
        scnt = 0;
      end
      if (Get_CMD_Complite) begin
        Get_CMD_Complite = 1'b0;
      end else if (Get_CMD_En && !get_never) begin
        if (gcnt == get_lat) begin
          Get_CMD_Complite = 1'b1;
          gcnt = 0;
          Responce_R1_R3 = ({44'd0, card_now} << 17) | err_mask;
          if (last_cmd == 6'd7) get7++;
        end else begin
          gcnt++;
        end
      end else begin
        gcnt = 0;
      end
    end
  end

  task automatic idle(input int n);
    Req_En = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_req(input string tag, input logic tgt, output int cyc);
    Target_Sel = tgt;
    Req_En = 1'b1;
    cyc = 0;
    while (!(Done || Fail) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_finished"}, 64'(cyc < 500), 64'(1));
  endtask

  task automatic wait_send(input string tag);
    int cyc;
    cyc = 0;
    while (!Send_CMD_En && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_send_seen"}, 64'(Send_CMD_En), 64'(1));
  endtask

  int cyc, b13, b7, bg7, bgc;

  task automatic snap();
    b13 = cnt13; b7 = cnt7; bg7 = get7; bgc = getcyc;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_done",  64'(Done),        64'(0));
    check_eq("rst_fail",  64'(Fail),        64'(0));
    check_eq("rst_code",  64'(Fail_Code),   64'(0));
    check_eq("rst_state", 64'(Card_State),  64'(0));
    check_eq("rst_cmdid", 64'(CMD_ID),      64'(0));
    check_eq("rst_send",  64'(Send_CMD_En), 64'(0));
    check_eq("rst_get",   64'(Get_CMD_En),  64'(0));
    rst = 1'b0;

    // Card already in TRAN, select requested
    card_cfg = 4'd4; idle(2); snap();
    run_req("tran", 1'b0, cyc);
    check_eq("tran_latency", 64'(cyc), 64'(12));
    check_eq("tran_done",    64'(Done), 64'(1));
    check_eq("tran_fail",    64'(Fail), 64'(0));
    check_eq("tran_state",   64'(Card_State), 64'(4));
    check_eq("tran_n13",     64'(cnt13 - b13), 64'(1));
    check_eq("tran_n7",      64'(cnt7 - b7), 64'(0));
    Req_En = 1'b0; @(negedge clk);
    check_eq("tran_done_clr", 64'(Done), 64'(0));

    // STBY -> TRAN via CMD7 select
    card_cfg = 4'd3; idle(2); snap();
    run_req("sel", 1'b0, cyc);
    check_eq("sel_done",  64'(Done), 64'(1));
    check_eq("sel_n13",   64'(cnt13 - b13), 64'(2));
    check_eq("sel_n7",    64'(cnt7 - b7), 64'(1));
    check_eq("sel_arg",   64'(arg7), 64'({RCA, 16'h0000}));
    check_eq("sel_get7",  64'(get7 - bg7), 64'(1));
    check_eq("sel_state", 64'(Card_State), 64'(4));

    // TRAN -> STBY via CMD7 deselect
    card_cfg = 4'd4; idle(2); snap();
    run_req("desel", 1'b1, cyc);
    check_eq("desel_done",  64'(Done), 64'(1));
    check_eq("desel_n13",   64'(cnt13 - b13), 64'(2));
    check_eq("desel_arg",   64'(arg7), 64'(0));
    check_eq("desel_get7",  64'(get7 - bg7), 64'(0));
    check_eq("desel_state", 64'(Card_State), 64'(3));

    // Card stuck in PRG: 1 + MR polls then retries exhausted
    card_cfg = 4'd7; idle(2); snap();
    run_req("prg", 1'b0, cyc);
    check_eq("prg_fail", 64'(Fail), 64'(1));
    check_eq("prg_done", 64'(Done), 64'(0));
    check_eq("prg_code", 64'(Fail_Code), 64'(3));
    check_eq("prg_n13",  64'(cnt13 - b13), 64'(4));
    Req_En = 1'b0; @(negedge clk);
    check_eq("prg_fail_clr", 64'(Fail), 64'(0));
    check_eq("prg_code_clr", 64'(Fail_Code), 64'(0));

    // Response never arrives
    card_cfg = 4'd4; get_never = 1'b1; idle(2); snap();
    run_req("rto", 1'b0, cyc);
    check_eq("rto_fail",   64'(Fail), 64'(1));
    check_eq("rto_code",   64'(Fail_Code), 64'(4));
    check_eq("rto_cycles", 64'(getcyc - bgc), 64'(RTO));
    get_never = 1'b0;

    // Completion on the expiry cycle wins
    get_lat = RTO - 1; idle(2);
    run_req("edge", 1'b0, cyc);
    check_eq("edge_done", 64'(Done), 64'(1));
    check_eq("edge_fail", 64'(Fail), 64'(0));
    get_lat = 1;

    // R1 error bit 31
    err_mask = 48'h1 << 31; idle(2); snap();
    run_req("r1err", 1'b0, cyc);
    check_eq("r1err_fail", 64'(Fail), 64'(1));
    check_eq("r1err_code", 64'(Fail_Code), 64'(5));
    check_eq("r1err_excl", 64'(Done & Fail), 64'(0));
    err_mask = '0;

    // Card stays busy
    Busy_Bit = 1'b0; idle(2); snap();
    run_req("busy", 1'b0, cyc);
    check_eq("busy_code", 64'(Fail_Code), 64'(1));
    check_eq("busy_n13",  64'(cnt13 - b13), 64'(0));
    Busy_Bit = 1'b1;

    // Abort during SEND_CMD13
    send_never = 1'b1; idle(2);
    Target_Sel = 1'b0; Req_En = 1'b1;
    wait_send("abort");
    Req_En = 1'b0;
    @(negedge clk);
    check_eq("abort_send", 64'(Send_CMD_En), 64'(0));
    check_eq("abort_get",  64'(Get_CMD_En), 64'(0));
    repeat (3) @(negedge clk);
    check_eq("abort_fail", 64'(Fail), 64'(0));
    check_eq("abort_code", 64'(Fail_Code), 64'(0));
    send_never = 1'b0; idle(2);
    run_req("after_abort", 1'b0, cyc);
    check_eq("after_abort_done", 64'(Done), 64'(1));

    // Asynchronous reset mid-command
    send_never = 1'b1; idle(2);
    Req_En = 1'b1;
    wait_send("arst");
    #2 rst = 1'b1;
    #1;
    check_eq("arst_send",  64'(Send_CMD_En), 64'(0));
    check_eq("arst_cmdid", 64'(CMD_ID), 64'(0));
    Req_En = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_never = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
